chimera_hart_irq_gen: RTL

SoC-side generator of per-hart machine software (msip) and timer (mtip) interrupts for all Snitch harts in the cluster domain. It drives the flat per-hart msip/mtip vectors that the cluster domain slices per cluster, using the same index order (cluster 0 cores first). A CLINT-compatible register file is exposed on a reg-interface responder port. It holds a 64-bit mtime counter advanced by an RTC tick, plus one 64-bit mtimecmp per hart.

---
 rtl/chimera_pkg.sv | 36 +++
 rtl/chimera_hart_timer_cmp.sv | 30 +++
 rtl/chimera_hart_irq_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/chimera_pkg.sv
// Register map constants, reg-interface structs and the byte-strobe merge helper
// shared by the hart interrupt generator.
package chimera_pkg;

    localparam int unsigned DefAddrWidth = 16;

    localparam logic [31:0] MsipOffset     = 32'h0000_0000;
    localparam logic [31:0] MtimecmpOffset = 32'h0000_4000;
    localparam logic [31:0] MtimeOffset    = 32'h0000_BFF8;

    typedef struct packed {
        logic [DefAddrWidth-1:0] addr;
        logic                    write;
        logic [31:0]             wdata;
        logic [3:0]              wstrb;
        logic                    valid;
    } chimera_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } chimera_reg_rsp_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/chimera_hart_timer_cmp.sv
// One hart's 64-bit mtimecmp register with byte-strobed word writes and a
// registered mtime >= mtimecmp compare driving that hart's timer interrupt.
module chimera_hart_timer_cmp
    import chimera_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        mtip
);

    // The compare uses the registered mtime/mtimecmp, so a write or tick at
    // edge k shows on mtip at edge k+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= '1;
            mtip     <= 1'b0;
        end else begin
            if (we_lo) mtimecmp[31:0]  <= apply_wstrb(mtimecmp[31:0], wdata, wstrb);
            if (we_hi) mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], wdata, wstrb);
            mtip <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/chimera_hart_irq_gen.sv
// CLINT-style msip/mtip generator for all cluster harts: register port FSM,
// address decode, the mtime counter and the per-hart MSIP bits.
module chimera_hart_irq_gen
    import chimera_pkg::*;
#(
    parameter int unsigned NumHarts  = 16,
    parameter int unsigned AddrWidth = 16,
    parameter type reg_req_t = chimera_reg_req_t,
    parameter type reg_rsp_t = chimera_reg_rsp_t
) (
    input  logic                soc_clk_i,
    input  logic                rst_i,
    input  logic                rtc_tick_i,
    input  reg_req_t            reg_req_i,
    output reg_rsp_t            reg_rsp_o,
    output logic [NumHarts-1:0] msip_o,
    output logic [NumHarts-1:0] mtip_o,
    output logic [0:0]          fsm_state_o
);

    localparam int unsigned HartIdxW = (NumHarts > 1) ? $clog2(NumHarts) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [0:0]          state;
    logic [31:0]         rsp_rdata;
    logic                rsp_error;
    logic [63:0]         mtime_q;
    logic [NumHarts-1:0] msip_q;
    logic [63:0]         cmp_val [NumHarts];

    logic [31:0]         off;
    logic                sel_msip, sel_cmp, sel_mtime, dec_err, hi_word;
    logic [HartIdxW-1:0] h_msip, h_cmp;
    logic [31:0]         rdata_nxt;
    logic                accept, do_write;
    logic                msip_we, mtime_we_lo, mtime_we_hi;

    // Handshake: a request is taken in IDLE when valid=1 (writes commit and
    // read data is captured at that edge); the following RESP cycle shows
    // ready=1 with the registered rdata/error, then the FSM returns to IDLE.
    // The requester holds valid until it sees ready and then drops it.
    always_comb begin
        off       = 32'(reg_req_i.addr[AddrWidth-1:0]) & 32'hFFFF_FFFC;
        sel_msip  = (off - MsipOffset) < 32'(4 * NumHarts);
        sel_cmp   = (off >= MtimecmpOffset) && ((off - MtimecmpOffset) < 32'(8 * NumHarts));
        sel_mtime = (off[31:3] == MtimeOffset[31:3]);
        dec_err   = !(sel_msip || sel_cmp || sel_mtime);
        hi_word   = off[2];
        h_msip    = HartIdxW'((off - MsipOffset) >> 2);
        h_cmp     = HartIdxW'((off - MtimecmpOffset) >> 3);

        rdata_nxt = '0;
        if (sel_msip) begin
            rdata_nxt = {31'b0, msip_q[h_msip]};
        end else if (sel_cmp) begin
            rdata_nxt = hi_word ? cmp_val[h_cmp][63:32] : cmp_val[h_cmp][31:0];
        end else if (sel_mtime) begin
            rdata_nxt = hi_word ? mtime_q[63:32] : mtime_q[31:0];
        end
    end

    assign accept      = (state == IDLE) && reg_req_i.valid;
    assign do_write    = accept && reg_req_i.write && !dec_err;
    assign msip_we     = do_write && sel_msip;
    assign mtime_we_lo = do_write && sel_mtime && !hi_word;
    assign mtime_we_hi = do_write && sel_mtime && hi_word;

    always_ff @(posedge soc_clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reg_req_i.valid) begin
                        state     <= RESP;
                        rsp_rdata <= rdata_nxt;
                        rsp_error <= dec_err;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_rdata <= '0;
                    rsp_error <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A register write beats a same-cycle tick; the unwritten half keeps its value.
    always_ff @(posedge soc_clk_i) begin
        if (rst_i) begin
            mtime_q <= '0;
        end else if (mtime_we_lo || mtime_we_hi) begin
            if (mtime_we_lo) mtime_q[31:0]  <= apply_wstrb(mtime_q[31:0], reg_req_i.wdata, reg_req_i.wstrb);
            if (mtime_we_hi) mtime_q[63:32] <= apply_wstrb(mtime_q[63:32], reg_req_i.wdata, reg_req_i.wstrb);
        end else if (rtc_tick_i) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    always_ff @(posedge soc_clk_i) begin
        if (rst_i) begin
            msip_q <= '0;
        end else if (msip_we && reg_req_i.wstrb[0]) begin
            msip_q[h_msip] <= reg_req_i.wdata[0];
        end
    end

    for (genvar h = 0; h < NumHarts; h++) begin : g_hart
        chimera_hart_timer_cmp u_cmp (
            .clk      (soc_clk_i),
            .rst      (rst_i),
            .we_lo    (do_write && sel_cmp && !hi_word && (h_cmp == HartIdxW'(h))),
            .we_hi    (do_write && sel_cmp && hi_word && (h_cmp == HartIdxW'(h))),
            .wdata    (reg_req_i.wdata),
            .wstrb    (reg_req_i.wstrb),
            .mtime    (mtime_q),
            .mtimecmp (cmp_val[h]),
            .mtip     (mtip_o[h])
        );
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rsp_rdata;
        reg_rsp_o.error = rsp_error;
        reg_rsp_o.ready = (state == RESP);
    end

    assign msip_o      = msip_q;
    assign fsm_state_o = state;

endmodule
